// File: rtl/pipe_ctrl_nway.sv
// Stall/flush/redirect controller for the N-lane in-order pipeline.
// Resolves per-stage hold/clear masks, oldest-lane redirect, fence/WFI sequencing and D-side occupancy.

module pipe_ctrl_lane (
  input  logic older_br_i,
  input  logic flag_i,
  output logic kill_o,
  output logic older_br_o
);
  // A lane dies if any older lane redirects; the chain carries "an older lane branched".
  assign kill_o     = older_br_i;
  assign older_br_o = older_br_i | flag_i;
endmodule

module pipe_ctrl_nway #(
  parameter int LANES      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_W      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        icache_stall_req,
  input  logic                        dcache_stall_req,
  input  logic                        hazard_stall_req,
  input  logic                        ex_stall_req,
  input  logic [LANES-1:0]            dec_fence,
  input  logic [LANES-1:0]            dec_wfi,
  input  logic [LANES-1:0]            ex_ldst,
  input  logic [LANES-1:0]            mem_ldst,
  input  logic [LANES-1:0]            ex_branch_flag,
  input  logic [LANES*ADDR_WIDTH-1:0] ex_branch_pc,
  input  logic                        csr_excp_flag,
  input  logic [ADDR_WIDTH-1:0]       csr_excp_pc,
  input  logic                        csr_wfi_wakeup,
  input  logic                        mem_req,
  input  logic                        mem_ack,
  output logic [4:0]                  stall,
  output logic [3:0]                  flush,
  output logic [LANES-1:0]            lane_kill_ex,
  output logic                        redirect_valid,
  output logic [ADDR_WIDTH-1:0]       redirect_pc,
  output logic [CNT_W-1:0]            outstanding,
  output logic [1:0]                  ctrl_state
);

  typedef enum logic [1:0] {RUN = 2'd0, FENCE_DRAIN = 2'd1, WFI_SLEEP = 2'd2, WAKE = 2'd3} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       outstanding_q, outstanding_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [ADDR_WIDTH-1:0]  pend_pc_q, pend_pc_d;

  logic [LANES:0]         older_br;
  logic [LANES-1:0]       kill_chain;
  logic                   br_any, busy;
  logic [ADDR_WIDTH-1:0]  br_tgt;

  assign older_br[0] = 1'b0;
  assign br_any      = older_br[LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pipe_ctrl_lane u_lane (
      .older_br_i (older_br[g]),
      .flag_i     (ex_branch_flag[g]),
      .kill_o     (kill_chain[g]),
      .older_br_o (older_br[g+1])
    );
  end

  // Scan from youngest down so the oldest flagged lane's target is the one left standing.
  always_comb begin
    br_tgt = '0;
    for (int i = LANES-1; i >= 0; i--)
      if (ex_branch_flag[i]) br_tgt = ex_branch_pc[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  assign busy = (outstanding_q != '0) || (|ex_ldst) || (|mem_ldst);

  always_comb begin
    outstanding_d = outstanding_q;
    if (mem_req && !mem_ack && outstanding_q != '1)
      outstanding_d = outstanding_q + CNT_W'(1);
    else if (mem_ack && !mem_req && outstanding_q != '0)
      outstanding_d = outstanding_q - CNT_W'(1);
  end

  always_comb begin
    stall          = '0;
    flush          = '0;
    lane_kill_ex   = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    state_d        = state_q;
    pend_valid_d   = pend_valid_q;
    pend_pc_d      = pend_pc_q;

    if (csr_excp_flag) begin
      flush          = 4'hF;
      lane_kill_ex   = '1;
      redirect_valid = 1'b1;
      redirect_pc    = csr_excp_pc;
      state_d        = RUN;
      pend_valid_d   = 1'b0;
    end else begin
      if (pend_valid_q) begin
        if (!icache_stall_req) begin
          redirect_valid = 1'b1;
          redirect_pc    = pend_pc_q;
          pend_valid_d   = 1'b0;
        end
      end else if (state_q == RUN && br_any) begin
        flush        = 4'b0011;
        lane_kill_ex = kill_chain;
        if (!icache_stall_req) begin
          redirect_valid = 1'b1;
          redirect_pc    = br_tgt;
        end else begin
          pend_valid_d = 1'b1;
          pend_pc_d    = br_tgt;
        end
      end

      case (state_q)
        RUN: begin
          if (|dec_wfi) begin
            stall   = 5'h1F;
            state_d = WFI_SLEEP;
          end else if (hazard_stall_req) begin
            stall    = 5'b00011;
            flush[1] = 1'b1;
          end else if (dcache_stall_req || ex_stall_req) begin
            stall    = 5'b00111;
            flush[2] = 1'b1;
          end else if ((|dec_fence) && busy) begin
            stall    = 5'b00011;
            flush[1] = 1'b1;
            state_d  = FENCE_DRAIN;
          end else if (icache_stall_req) begin
            stall    = 5'b00001;
            flush[0] = 1'b1;
          end
        end
        FENCE_DRAIN: begin
          if (busy) begin
            stall    = 5'b00011;
            flush[1] = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        WFI_SLEEP: begin
          stall = 5'h1F;
          if (csr_wfi_wakeup) state_d = WAKE;
        end
        WAKE: begin
          stall    = 5'b00001;
          flush[0] = 1'b1;
          state_d  = RUN;
        end
        default: state_d = RUN;
      endcase
    end

    // Reset wins over everything: hold every pipeline register cleared.
    if (!rst_n) begin
      stall          = '0;
      flush          = 4'hF;
      lane_kill_ex   = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      outstanding_q <= '0;
      pend_valid_q  <= 1'b0;
      pend_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      pend_valid_q  <= pend_valid_d;
      pend_pc_q     <= pend_pc_d;
    end
  end

  assign outstanding = outstanding_q;
  assign ctrl_state  = state_q;

endmodule
